// File: rtl/dp_vector_accel_pkg.sv
// Shared definitions for the vector dot-product accelerator:
// register word addresses and the run-control state enumeration.
package dp_vector_accel_pkg;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;  // W: start (bit0), R: status
    localparam logic [2:0] ADDR_LEN     = 3'd1;  // R/W: element count, clamped to DEPTH
    localparam logic [2:0] ADDR_A_PUSH  = 3'd2;  // W: append to vector A
    localparam logic [2:0] ADDR_B_PUSH  = 3'd3;  // W: append to vector B
    localparam logic [2:0] ADDR_RES_LO  = 3'd4;  // R: accumulator low word
    localparam logic [2:0] ADDR_RES_HI  = 3'd5;  // R: accumulator high word
    localparam logic [2:0] ADDR_PTR_CLR = 3'd6;  // W: clear pointers, done, overflow
    localparam logic [2:0] ADDR_CYCLES  = 3'd7;  // R: MAC cycles of latest run

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dp_vector_accel_mac.sv
// Signed multiply-accumulate step with overflow detection.
// Ports:
//   i_a, i_b  : signed vector elements (DATA_W)
//   i_acc     : current accumulator (ACC_W)
//   o_sum     : i_acc + sign-extended(i_a*i_b), modulo 2^ACC_W
//   o_ovf     : this add left the signed ACC_W range
module dp_mac
    import dp_vector_accel_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ACC_W  = 64
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [ACC_W-1:0]  i_acc,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_ovf
);

    logic signed [2*DATA_W-1:0] w_a_ext;
    logic signed [2*DATA_W-1:0] w_b_ext;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;

    // Operands widened first so the product is formed at full width.
    assign w_a_ext    = (2*DATA_W)'($signed(i_a));
    assign w_b_ext    = (2*DATA_W)'($signed(i_b));
    assign w_prod     = w_a_ext * w_b_ext;
    assign w_prod_ext = ACC_W'(w_prod);

    assign o_sum = i_acc + w_prod_ext;

    // Two's-complement overflow: like-signed addends, differently signed sum.
    assign o_ovf = (i_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (o_sum[ACC_W-1] != i_acc[ACC_W-1]);

endmodule

// File: rtl/dp_vector_accel.sv
// Vector dot-product accelerator behind a small 8-word register map.
// Software pushes vectors A and B, sets LEN, writes CTRL.start; the engine
// then accumulates one signed A[i]*B[i] per cycle.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   addr           : register word address
//   rd_en, wr_en   : read / write strobes (both may be high together)
//   dataIn         : write data
//   dataOut        : combinational read data, 0 when rd_en is low
module dp_vector_accel
    import dp_vector_accel_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ACC_W  = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [2:0]        addr,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    state_t             r_state;
    state_t             w_state_next;

    logic [DATA_W-1:0]  r_mem_a [DEPTH];
    logic [DATA_W-1:0]  r_mem_b [DEPTH];
    logic [PW-1:0]      r_ptr_a;
    logic [PW-1:0]      r_ptr_b;
    logic [LW-1:0]      r_len;
    logic [LW-1:0]      r_idx;
    logic [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_cycles;
    logic               r_done;
    logic               r_ovf;

    logic               w_busy;
    logic               w_start;
    logic               w_last;
    logic               w_wr_open;
    logic [ACC_W-1:0]   w_sum;
    logic               w_mac_ovf;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  w_res_hi;

    assign w_busy    = (r_state == ST_RUN);
    assign w_wr_open = wr_en && !w_busy;
    assign w_start   = w_wr_open && (addr == ADDR_CTRL) && dataIn[0];
    assign w_last    = (r_idx == r_len - LW'(1));

    dp_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_a    (r_mem_a[r_idx[PW-1:0]]),
        .i_b    (r_mem_b[r_idx[PW-1:0]]),
        .i_acc  (r_acc),
        .o_sum  (w_sum),
        .o_ovf  (w_mac_ovf)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) w_state_next = (r_len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_last) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath and registers ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr_a  <= '0;
            r_ptr_b  <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_cycles <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_start) begin
                r_acc    <= '0;
                r_idx    <= '0;
                r_ovf    <= 1'b0;
                r_cycles <= '0;
                // A zero-length run completes on the start edge itself.
                r_done   <= (r_len == '0);
            end else if (w_busy) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_mac_ovf;
                r_idx <= r_idx + LW'(1);
                if (r_cycles != '1) r_cycles <= r_cycles + DATA_W'(1);
                if (w_last) r_done <= 1'b1;
            end

            if (w_wr_open) begin
                case (addr)
                    ADDR_LEN: begin
                        if (dataIn > DATA_W'(DEPTH)) r_len <= LW'(DEPTH);
                        else                         r_len <= dataIn[LW-1:0];
                    end
                    ADDR_A_PUSH:  r_ptr_a <= r_ptr_a + PW'(1);
                    ADDR_B_PUSH:  r_ptr_b <= r_ptr_b + PW'(1);
                    ADDR_PTR_CLR: begin
                        r_ptr_a <= '0;
                        r_ptr_b <= '0;
                        r_done  <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Vector storage carries no reset.
    always_ff @(posedge clock) begin
        if (w_wr_open && (addr == ADDR_A_PUSH)) r_mem_a[r_ptr_a] <= dataIn;
        if (w_wr_open && (addr == ADDR_B_PUSH)) r_mem_b[r_ptr_b] <= dataIn;
    end

    // ---------------- read mux ----------------
    assign w_res_hi = DATA_W'(r_acc >> DATA_W);

    always_comb begin
        w_rdata = '0;
        case (addr)
            ADDR_CTRL: begin
                w_rdata[0]    = w_busy;
                w_rdata[1]    = r_done;
                w_rdata[2]    = r_ovf;
                w_rdata[15:8] = 8'(r_ptr_a);
            end
            ADDR_LEN:    w_rdata = DATA_W'(r_len);
            ADDR_RES_LO: w_rdata = r_acc[DATA_W-1:0];
            ADDR_RES_HI: w_rdata = w_res_hi;
            ADDR_CYCLES: w_rdata = r_cycles;
            default:     w_rdata = '0;
        endcase
    end

    assign dataOut = rd_en ? w_rdata : '0;

endmodule

// File: tb/tb_dp_vector_accel.sv
module tb_dp_vector_accel;
    import dp_vector_accel_pkg::*;

    logic        clock;
    logic        reset_n;
    logic [2:0]  addr;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    int errors = 0;
    int checks = 0;

    dp_vector_accel #(
        .DATA_W (32),
        .DEPTH  (16),
        .ACC_W  (64)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .addr    (addr),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        addr   = a;
        dataIn = d;
        wr_en  = 1'b1;
        @(posedge clock);
        #1;
        wr_en  = 1'b0;
        dataIn = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr  = a;
        rd_en = 1'b1;
        #1;
        d     = dataOut;
        rd_en = 1'b0;
        #1;
    endtask

    task automatic load_basic();
        wr(ADDR_PTR_CLR, 32'd0);
        wr(ADDR_LEN, 32'd4);
        for (int i = 0; i < 4; i++) wr(ADDR_A_PUSH, 32'(i + 1));
        for (int i = 0; i < 4; i++) wr(ADDR_B_PUSH, 32'(i + 5));
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0;
        #22;
        reset_n = 1'b1;
        #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected %h", v, 32'h0); end
        rd(ADDR_LEN, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_len: got %h expected %h", v, 32'h0); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_res_lo: got %h expected %h", v, 32'h0); end
        rd(ADDR_CYCLES, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cycles: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_basic_dot();
        logic [31:0] v;
        load_basic();
        wr(ADDR_CTRL, 32'd1);
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL basic_busy_after_start: got %h expected %h", v, 32'h0000_0401); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            rd(ADDR_CTRL, v);
            checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL basic_busy_cycle%0d: got %h expected %h", k, v, 32'h0000_0401); end
        end
        @(posedge clock); #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0000_0402) begin errors++; $display("FAIL basic_done: got %h expected %h", v, 32'h0000_0402); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd70) begin errors++; $display("FAIL basic_res_lo: got %h expected %h", v, 32'd70); end
        rd(ADDR_RES_HI, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL basic_res_hi: got %h expected %h", v, 32'd0); end
        rd(ADDR_CYCLES, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL basic_cycles: got %h expected %h", v, 32'd4); end
        // read-only and unmapped locations
        wr(ADDR_RES_LO, 32'h1234);
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd70) begin errors++; $display("FAIL ro_res_lo_write: got %h expected %h", v, 32'd70); end
        rd(ADDR_A_PUSH, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL unmapped_a_push_read: got %h expected %h", v, 32'd0); end
    endtask

    task automatic test_signed();
        logic [31:0] v;
        wr(ADDR_PTR_CLR, 32'd0);
        wr(ADDR_LEN, 32'd2);
        wr(ADDR_A_PUSH, 32'hFFFF_FFFD);  // -3
        wr(ADDR_A_PUSH, 32'd2);
        wr(ADDR_B_PUSH, 32'd4);
        wr(ADDR_B_PUSH, 32'hFFFF_FFFB);  // -5
        wr(ADDR_CTRL, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'hFFFF_FFEA) begin errors++; $display("FAIL signed_res_lo: got %h expected %h", v, 32'hFFFF_FFEA); end
        rd(ADDR_RES_HI, v);
        checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL signed_res_hi: got %h expected %h", v, 32'hFFFF_FFFF); end
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0000_0202) begin errors++; $display("FAIL signed_status: got %h expected %h", v, 32'h0000_0202); end
    endtask

    task automatic test_len_zero_and_clamp();
        logic [31:0] v;
        wr(ADDR_LEN, 32'd0);
        wr(ADDR_CTRL, 32'd1);
        rd(ADDR_CTRL, v);
        checks++; if (v[2:0] !== 3'b010) begin errors++; $display("FAIL len0_done_next_cycle: got %b expected %b", v[2:0], 3'b010); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL len0_result: got %h expected %h", v, 32'd0); end
        wr(ADDR_LEN, 32'd40);
        rd(ADDR_LEN, v);
        checks++; if (v !== 32'd16) begin errors++; $display("FAIL len_clamp: got %0d expected %0d", v, 16); end
        // simultaneous read and write returns the pre-write value
        @(negedge clock);
        addr = ADDR_LEN; dataIn = 32'd3; wr_en = 1'b1; rd_en = 1'b1;
        #1;
        v = dataOut;
        checks++; if (v !== 32'd16) begin errors++; $display("FAIL rdwr_old_value: got %0d expected %0d", v, 16); end
        @(posedge clock); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        rd(ADDR_LEN, v);
        checks++; if (v !== 32'd3) begin errors++; $display("FAIL rdwr_new_value: got %0d expected %0d", v, 3); end
        addr = ADDR_LEN; rd_en = 1'b0;
        #1;
        checks++; if (dataOut !== 32'd0) begin errors++; $display("FAIL rd_en_low_zero: got %h expected %h", dataOut, 32'd0); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        load_basic();
        wr(ADDR_CTRL, 32'd1);
        wr(ADDR_A_PUSH, 32'd100);
        wr(ADDR_LEN, 32'd1);
        wr(ADDR_CTRL, 32'd1);
        @(posedge clock); #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0000_0402) begin errors++; $display("FAIL busy_ignore_status: got %h expected %h", v, 32'h0000_0402); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd70) begin errors++; $display("FAIL busy_ignore_result: got %0d expected %0d", v, 70); end
        rd(ADDR_LEN, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL busy_ignore_len: got %0d expected %0d", v, 4); end
        rd(ADDR_CYCLES, v);
        checks++; if (v !== 32'd4) begin errors++; $display("FAIL busy_ignore_cycles: got %0d expected %0d", v, 4); end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        wr(ADDR_PTR_CLR, 32'd0);
        for (int i = 0; i < 17; i++) wr(ADDR_A_PUSH, 32'(10 + i));
        rd(ADDR_CTRL, v);
        checks++; if (v[15:8] !== 8'd1) begin errors++; $display("FAIL wrap_ptr: got %0d expected %0d", v[15:8], 1); end
        wr(ADDR_B_PUSH, 32'd1);
        wr(ADDR_LEN, 32'd1);
        wr(ADDR_CTRL, 32'd1);
        @(posedge clock); #1;
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd26) begin errors++; $display("FAIL wrap_elem0: got %0d expected %0d", v, 26); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        wr(ADDR_PTR_CLR, 32'd0);
        wr(ADDR_LEN, 32'd2);
        wr(ADDR_A_PUSH, 32'h8000_0000);
        wr(ADDR_A_PUSH, 32'h8000_0000);
        wr(ADDR_B_PUSH, 32'h8000_0000);
        wr(ADDR_B_PUSH, 32'h8000_0000);
        wr(ADDR_CTRL, 32'd1);
        repeat (2) @(posedge clock);
        #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0000_0206) begin errors++; $display("FAIL ovf_status: got %h expected %h", v, 32'h0000_0206); end
        rd(ADDR_RES_HI, v);
        checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL ovf_wrap_hi: got %h expected %h", v, 32'h8000_0000); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovf_wrap_lo: got %h expected %h", v, 32'h0); end
        wr(ADDR_PTR_CLR, 32'd0);
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ptr_clr_status: got %h expected %h", v, 32'h0); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v;
        load_basic();
        wr(ADDR_CTRL, 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'd17) begin errors++; $display("FAIL partial_sum: got %0d expected %0d", v, 17); end
        reset_n = 1'b0;
        #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrun_reset_status: got %h expected %h", v, 32'h0); end
        rd(ADDR_RES_LO, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrun_reset_res_lo: got %h expected %h", v, 32'h0); end
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        rd(ADDR_CTRL, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL midrun_reset_no_done: got %h expected %h", v, 32'h0); end
    endtask

    initial begin
        reset_n = 1'b0;
        addr    = '0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        dataIn  = '0;
        test_reset();
        test_basic_dot();
        test_signed();
        test_len_zero_and_clamp();
        test_back_to_back();
        test_wrap();
        test_overflow();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
